// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with word counter and double-buffered valid/ready output.
// Optional macro SIPO_PARITY_EN: frame gains a trailing even-parity bit checked into parity_err.
module sipo_deserializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    input  logic                     s_valid,
    input  logic                     clr,
    input  logic                     p_ready,
    output logic [N-1:0]             p_out,
    output logic                     p_valid,
    output logic                     overrun,
    output logic [$clog2(N+1)-1:0]   bit_cnt,
    output logic                     parity_err
);

    localparam int CW = $clog2(N + 1);
`ifdef SIPO_PARITY_EN
    localparam bit              PAR_EN = 1'b1;
    localparam logic [CW-1:0]   LAST   = CW'(N);
`else
    localparam bit              PAR_EN = 1'b0;
    localparam logic [CW-1:0]   LAST   = CW'(N - 1);
`endif

    logic [N-1:0] sr;
    logic [N-1:0] sr_shift;
    logic [N-1:0] word;
    logic         accept;
    logic         last;
    logic         complete;
    logic         shift_en;
    logic         par;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[N-2:0], b};
        else
            return {b, cur[N-1:1]};
    endfunction

    always_comb begin
        accept   = s_valid && !clr;
        last     = (bit_cnt == LAST);
        complete = accept && last;
        sr_shift = shift_in(sr, s_in);
        // With parity the final bit is the parity bit itself, so the data is already in sr.
        shift_en = accept && !(PAR_EN && last);
        word     = PAR_EN ? sr : sr_shift;
        par      = PAR_EN ? ((^sr) ^ s_in) : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            bit_cnt    <= '0;
            p_out      <= '0;
            p_valid    <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (clr) begin
                sr      <= '0;
                bit_cnt <= '0;
                overrun <= 1'b0;
            end else if (s_valid) begin
                bit_cnt <= last ? '0 : bit_cnt + CW'(1);
                if (shift_en)
                    sr <= sr_shift;
            end

            // A completed word lands only if the holding register is free or draining this edge.
            if (complete && (!p_valid || p_ready)) begin
                p_out      <= word;
                p_valid    <= 1'b1;
                parity_err <= par;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first instance on shared inputs.
module tb_sipo_deserializer;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_in = 1'b0;
    logic          s_valid = 1'b0;
    logic          clr = 1'b0;
    logic          p_ready = 1'b0;

    logic [N-1:0]  p_out_m, p_out_l;
    logic          p_valid_m, p_valid_l;
    logic          overrun_m, overrun_l;
    logic [CW-1:0] bit_cnt_m, bit_cnt_l;
    logic          parity_err_m, parity_err_l;

    int tests  = 0;
    int failed = 0;

`ifdef SIPO_PARITY_EN
    localparam int FULL_CNT = N;
`else
    localparam int FULL_CNT = 0;
`endif

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .clr(clr), .p_ready(p_ready),
        .p_out(p_out_m), .p_valid(p_valid_m), .overrun(overrun_m), .bit_cnt(bit_cnt_m),
        .parity_err(parity_err_m)
    );

    sipo_deserializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .clr(clr), .p_ready(p_ready),
        .p_out(p_out_l), .p_valid(p_valid_l), .overrun(overrun_l), .bit_cnt(bit_cnt_l),
        .parity_err(parity_err_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given serial inputs; outputs are stable #1 after the edge.
    task automatic tick(input logic v, input logic b);
        s_valid = v;
        s_in    = b;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_in    = 1'b0;
    endtask

    // Sends w MSB-of-w first; with parity adds the correct even-parity bit.
    // If ready_last is set, p_ready is raised just before the word's final edge.
    task automatic send_word(input logic [N-1:0] w, input logic ready_last);
        for (int i = N - 1; i >= 0; i--) begin
`ifndef SIPO_PARITY_EN
            if (i == 0 && ready_last) p_ready = 1'b1;
`endif
            tick(1'b1, w[i]);
        end
`ifdef SIPO_PARITY_EN
        if (ready_last) p_ready = 1'b1;
        tick(1'b1, ^w);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        chk("rst_p_out", p_out_m, 0);
        chk("rst_p_valid", p_valid_m, 0);
        chk("rst_overrun", overrun_m, 0);
        chk("rst_bit_cnt", bit_cnt_m, 0);
        chk("rst_parity_err", parity_err_m, 0);

        // 1,0,1,1 back to back with p_ready high
        p_ready = 1'b1;
        tick(1'b1, 1'b1); chk("cnt_1", bit_cnt_m, 1);
        tick(1'b1, 1'b0); chk("cnt_2", bit_cnt_m, 2);
        tick(1'b1, 1'b1); chk("cnt_3", bit_cnt_m, 3);
        tick(1'b1, 1'b1); chk("cnt_wrap", bit_cnt_m, FULL_CNT);
`ifdef SIPO_PARITY_EN
        tick(1'b1, 1'b1); chk("cnt_wrap_par", bit_cnt_m, 0);
`endif
        chk("msb_p_valid", p_valid_m, 1);
        chk("msb_p_out", p_out_m, 4'b1011);
        chk("lsb_p_out", p_out_l, 4'b1101);
        tick(1'b0, 1'b0);
        chk("msb_one_cycle", p_valid_m, 0);

        // Same stream with 2-cycle gaps
        do_reset();
        tick(1'b1, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        chk("gap_hold", bit_cnt_l, 1);
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b1, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        chk("gap_hold3", bit_cnt_l, 3);
        chk("gap_no_word", p_valid_l, 0);
        p_ready = 1'b0;
        tick(1'b1, 1'b1);
`ifdef SIPO_PARITY_EN
        tick(1'b0, 1'b0); tick(1'b1, 1'b1);
`endif
        chk("gap_lsb_p_out", p_out_l, 4'b1101);
        chk("gap_msb_p_out", p_out_m, 4'b1011);
        chk("gap_p_valid", p_valid_l, 1);

        // Overrun: A then 5 with p_ready low
        do_reset();
        p_ready = 1'b0;
        send_word(4'hA, 1'b0);
        chk("ovr_first", p_out_m, 4'hA);
        chk("ovr_not_yet", overrun_m, 0);
        send_word(4'h5, 1'b0);
        chk("ovr_hold", p_out_m, 4'hA);
        chk("ovr_lsb_hold", p_out_l, 4'h5);
        chk("ovr_set", overrun_m, 1);
        chk("ovr_valid", p_valid_m, 1);
        p_ready = 1'b1;
        tick(1'b0, 1'b0);
        chk("ovr_drain", p_valid_m, 0);
        chk("ovr_sticky", overrun_m, 1);
        clr = 1'b1;
        tick(1'b0, 1'b0);
        clr = 1'b0;
        chk("ovr_clr", overrun_m, 0);

        // Back-to-back: 3 pending, C's final edge coincides with p_ready
        do_reset();
        p_ready = 1'b0;
        send_word(4'h3, 1'b0);
        chk("b2b_first", p_out_m, 4'h3);
        send_word(4'hC, 1'b1);
        chk("b2b_p_out", p_out_m, 4'hC);
        chk("b2b_p_valid", p_valid_m, 1);
        chk("b2b_overrun", overrun_m, 0);

        // clr with s_valid mid-word, then 9
        do_reset();
        p_ready = 1'b0;
        tick(1'b1, 1'b1); tick(1'b1, 1'b0);
        clr = 1'b1;
        tick(1'b1, 1'b1);
        clr = 1'b0;
        chk("clr_cnt", bit_cnt_m, 0);
        chk("clr_no_word", p_valid_m, 0);
        send_word(4'h9, 1'b0);
        chk("clr_p_out", p_out_m, 4'h9);
        chk("clr_lsb_p_out", p_out_l, 4'h9);
        chk("clr_p_valid", p_valid_m, 1);

        // Async reset after 3 bits
        tick(1'b1, 1'b1); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        chk("pre_rst_cnt", bit_cnt_m, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_p_out", p_out_m, 0);
        chk("arst_p_valid", p_valid_m, 0);
        chk("arst_cnt", bit_cnt_m, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tick(1'b1, 1'b0);
        chk("arst_no_word", p_valid_m, 0);
        chk("arst_cnt_restart", bit_cnt_m, 1);

`ifdef SIPO_PARITY_EN
        do_reset();
        p_ready = 1'b1;
        tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("par_ok_err", parity_err_m, 0);
        chk("par_ok_out", p_out_m, 4'b1011);
        tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        chk("par_bad_err", parity_err_m, 1);
        chk("par_bad_out", p_out_m, 4'b1011);
        chk("par_bad_valid", p_valid_m, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
N-bit serial-in parallel-out shift register with a word-assembly counter and a valid/ready output handshake. It is the receiving end of the team's parallel-in serial-out shifter. Serial bits qualified by s_valid are collected into a shift register, and each completed word is transferred to a holding register offered downstream. Double buffering lets the next word assemble while the previous one waits for p_ready.

Parameters:
N, 4, word width in bits; legal range N >= 2
MSB_FIRST, 1, 1 = first received bit lands in p_out[N-1]; 0 = first received bit lands in p_out[0]

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
s_in  input  1  serial data bit
s_valid  input  1  s_in is sampled at this edge when high
clr  input  1  synchronous frame restart
p_ready  input  1  downstream accepts p_out
p_out  output  N  assembled parallel word (holding register)
p_valid  output  1  p_out holds an unconsumed word
overrun  output  1  sticky: a completed word was dropped
bit_cnt  output  $clog2(N+1)  bits accepted in the current word, 0..N-1
parity_err  output  1  parity result for p_out; 0 when SIPO_PARITY_EN is not defined

Behaviour:
- Reset is asynchronous. On rst: shift register = 0, bit_cnt = 0, p_out = 0, p_valid = 0, overrun = 0, parity_err = 0. Reset mid-word discards the partial word with no output.
- Shift rule, applied at an edge with s_valid=1:
  - MSB_FIRST=1: sr <= {sr[N-2:0], s_in}
  - MSB_FIRST=0: sr <= {s_in, sr[N-1:1]}
  - If s_valid=0, sr and bit_cnt hold. Gaps of any length are allowed.
- Counter: bit_cnt increments on each accepted bit. When the accepted bit is the last of the frame (bit_cnt==N-1), the word completes:
  - bit_cnt wraps to 0.
  - The completed word (sr including this bit) goes to p_out per the rules below.
  - The shift register need not be cleared; the next word fully overwrites it.
- Latency: p_out and p_valid update at the same edge that samples the final bit, so they are visible in the following cycle. There is no additional pipeline stage.
- Handshake:
  - A transfer occurs at an edge where p_valid=1 and p_ready=1. p_valid clears unless a word completes at the same edge.
  - Completion with p_valid=0: load p_out and set p_valid=1.
  - Completion with a transfer at the same edge: load p_out and keep p_valid=1. No overrun.
  - Completion with p_valid=1 and p_ready=0: drop the new word, leave p_out and p_valid unchanged, set overrun=1.
  - p_out is stable while p_valid=1 and p_ready=0.
  - p_ready while p_valid=0 has no effect.
- clr (synchronous):
  - Sets bit_cnt=0 and sr=0, and clears overrun.
  - Has priority over s_valid at the same edge; that bit is discarded.
  - Does not affect p_out or p_valid, so the handshake at that edge proceeds normally.
- overrun stays set until clr or rst.

Optional Feature:
SIPO_PARITY_EN
- Defined:
  - A frame is N data bits plus one trailing even-parity bit, so bit_cnt counts 0..N.
  - The word completes on the parity bit's edge; the parity bit is not shifted into sr.
  - parity_err = ^data ^ parity_bit, loaded alongside p_out and under the same handshake and overrun rules.
  - A word with a parity error is still delivered.
- Not defined: frame is N bits, and parity_err is tied to 0.

Test Plan:
- N=4, MSB_FIRST=1: s_in 1,0,1,1 on consecutive s_valid edges, p_ready=1 -> p_out=4'b1011 and p_valid=1 for exactly one cycle after the 4th edge; bit_cnt sequence 1,2,3,0.
- N=4, MSB_FIRST=0: same stream with 2-cycle s_valid gaps between bits -> p_out=4'b1101; bit_cnt holds during gaps.
- p_ready=0: send words 4'hA then 4'h5 -> p_out stays 4'hA and overrun=1 after the 8th bit. Then p_ready=1 -> p_valid clears. Then clr -> overrun=0.
- Back-to-back: word 4'h3 pending; the final bit of 4'hC arrives at the edge where p_ready=1 -> p_out=4'hC, p_valid stays 1, overrun=0.
- Two bits sent, then clr together with s_valid at one edge, then 4 bits of 4'h9 -> p_out=4'h9. Separately, rst asserted after 3 bits -> all outputs 0, no word emitted.
- SIPO_PARITY_EN, N=4: data 1011 + parity 1 -> parity_err=0; data 1011 + parity 0 -> parity_err=1, p_out=4'b1011 in both cases.
